// File: rtl/minisys_io_pkg.sv
// Shared constants for the Minisys board IO front end.
// Holds default widths, button index map and the simulation debounce length.
`timescale 1ns/1ps

package minisys_io_pkg;

    // Board default widths
    localparam int SW_WIDTH_DFLT  = 24;
    localparam int BTN_WIDTH_DFLT = 5;

    // Button index map (indices 1..3 are reserved)
    localparam int BTN_STEP  = 0;
    localparam int BTN_RESET = 4;

    typedef enum logic [2:0] {
        BTN_IDX_STEP  = 3'd0,
        BTN_IDX_RSV1  = 3'd1,
        BTN_IDX_RSV2  = 3'd2,
        BTN_IDX_RSV3  = 3'd3,
        BTN_IDX_RESET = 3'd4
    } btn_idx_e;

    // Short debounce window used by simulation benches
    localparam int DEBOUNCE_SIM = 4;

    // Counter width able to hold 0..cycles
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/minisys_input_conditioner_debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus a debounce counter for a WIDTH-bit word.
// Ports: clock, reset_n, i_raw (async in), o_stable (debounced), o_rise/o_fall (1-cycle pulses).
`timescale 1ns/1ps

module debounce_cell
    import minisys_io_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    // For a multi-bit word any bit difference keeps the count running;
    // the word accepted is whatever sync2 holds on the accepting edge.
    assign w_differ = (r_sync2 != r_stable);
    assign w_accept = w_differ && (r_cnt == LP_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            r_cnt    <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                // Pulses share the edge of the level update
                r_rise   <= r_sync2 & ~r_stable;
                r_fall   <= ~r_sync2 & r_stable;
            end else if (w_differ) begin
                r_cnt <= r_cnt + LP_ONE;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/minisys_input_conditioner.sv
// Minisys board input front end: synchronises and debounces switches and buttons.
// Ports: clock, reset_n, switches_raw/buttons_raw in; stable levels and change pulses out.
`timescale 1ns/1ps

module minisys_input_conditioner
    import minisys_io_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DFLT,
    parameter int BTN_WIDTH       = BTN_WIDTH_DFLT,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [SW_WIDTH-1:0]  switches_raw,
    input  logic [BTN_WIDTH-1:0] buttons_raw,
    output logic [SW_WIDTH-1:0]  switches_stable,
    output logic                 switches_changed,
    output logic [BTN_WIDTH-1:0] buttons_level,
    output logic [BTN_WIDTH-1:0] buttons_press,
    output logic [BTN_WIDTH-1:0] buttons_release
);

    logic [SW_WIDTH-1:0] w_sw_rise;
    logic [SW_WIDTH-1:0] w_sw_fall;

    // Each button debounces on its own so presses never mask each other
    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
        debounce_cell #(
            .WIDTH           (1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_raw    (buttons_raw[g]),
            .o_stable (buttons_level[g]),
            .o_rise   (buttons_press[g]),
            .o_fall   (buttons_release[g])
        );
    end

    // The switch bank is debounced as a single word
    debounce_cell #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_raw    (switches_raw),
        .o_stable (switches_stable),
        .o_rise   (w_sw_rise),
        .o_fall   (w_sw_fall)
    );

    assign switches_changed = |(w_sw_rise | w_sw_fall);

endmodule

// File: tb/tb_minisys_input_conditioner.sv
// Bench for minisys_input_conditioner: directed scenarios plus random bouncing
// inputs, compared every cycle against a window-based behavioural model.
`timescale 1ns/1ps

module tb_minisys_input_conditioner;
    import minisys_io_pkg::*;

    localparam int DC = DEBOUNCE_SIM;
    localparam int SW = 24;
    localparam int BW = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [SW-1:0] switches_raw = '0;
    logic [BW-1:0] buttons_raw = '0;
    logic [SW-1:0] switches_stable;
    logic          switches_changed;
    logic [BW-1:0] buttons_level;
    logic [BW-1:0] buttons_press;
    logic [BW-1:0] buttons_release;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #1 clock = ~clock;

    minisys_input_conditioner #(
        .SW_WIDTH        (SW),
        .BTN_WIDTH       (BW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .switches_raw     (switches_raw),
        .buttons_raw      (buttons_raw),
        .switches_stable  (switches_stable),
        .switches_changed (switches_changed),
        .buttons_level    (buttons_level),
        .buttons_press    (buttons_press),
        .buttons_release  (buttons_release)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Model: a value is accepted when the last DC synchronised samples
    // seen at clock edges all differ from the current stable value.
    logic [BW-1:0] m_s1_b = '0, m_s2_b = '0;
    logic [SW-1:0] m_s1_w = '0, m_s2_w = '0;
    logic [BW-1:0] win_b [DC];
    logic [SW-1:0] win_w [DC];
    logic [BW-1:0] e_lvl = '0, e_press = '0, e_rel = '0;
    logic [SW-1:0] e_sw = '0;
    logic          e_chg = 1'b0;
    bit            all_d;

    initial begin
        for (int i = 0; i < DC; i++) begin
            win_b[i] = '0;
            win_w[i] = '0;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1_b = '0; m_s2_b = '0; m_s1_w = '0; m_s2_w = '0;
            for (int i = 0; i < DC; i++) begin
                win_b[i] = '0;
                win_w[i] = '0;
            end
            e_lvl = '0; e_press = '0; e_rel = '0; e_sw = '0; e_chg = 1'b0;
        end else begin
            for (int i = DC - 1; i > 0; i--) begin
                win_b[i] = win_b[i-1];
                win_w[i] = win_w[i-1];
            end
            win_b[0] = m_s2_b;
            win_w[0] = m_s2_w;
            e_press = '0; e_rel = '0; e_chg = 1'b0;
            for (int b = 0; b < BW; b++) begin
                all_d = 1'b1;
                for (int i = 0; i < DC; i++)
                    if (win_b[i][b] == e_lvl[b]) all_d = 1'b0;
                if (all_d) begin
                    if (m_s2_b[b]) e_press[b] = 1'b1;
                    else           e_rel[b]   = 1'b1;
                    e_lvl[b] = m_s2_b[b];
                end
            end
            all_d = 1'b1;
            for (int i = 0; i < DC; i++)
                if (win_w[i] == e_sw) all_d = 1'b0;
            if (all_d) begin
                e_chg = 1'b1;
                e_sw  = m_s2_w;
            end
            m_s2_b = m_s1_b; m_s1_b = buttons_raw;
            m_s2_w = m_s1_w; m_s1_w = switches_raw;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("m_level",   32'(buttons_level),    32'(e_lvl));
            chk("m_press",   32'(buttons_press),    32'(e_press));
            chk("m_release", 32'(buttons_release),  32'(e_rel));
            chk("m_sw",      32'(switches_stable),  32'(e_sw));
            chk("m_changed", 32'(switches_changed), 32'(e_chg));
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got 1 want 0");
        $fatal(1, "timeout");
    end

    int bh, sh;
    logic [4:0] pat3 [12];

    initial begin
        // 1: inputs high through reset
        reset_n = 1'b0;
        buttons_raw = 5'b11111;
        switches_raw = 24'hFFFFFF;
        cyc();
        cmp_en = 1'b1;
        repeat (2) cyc();
        chk("t1_rst_lvl", 32'(buttons_level), 0);
        chk("t1_rst_press", 32'(buttons_press), 0);
        chk("t1_rst_sw", 32'(switches_stable), 0);
        chk("t1_rst_chg", 32'(switches_changed), 0);
        #0.5 reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("t1_press_early", 32'(buttons_press), 0);
        end
        cyc();
        chk("t1_press", 32'(buttons_press), 32'h1F);
        chk("t1_lvl", 32'(buttons_level), 32'h1F);
        chk("t1_sw", 32'(switches_stable), 32'hFFFFFF);
        chk("t1_chg", 32'(switches_changed), 1);
        cyc();
        chk("t1_press_end", 32'(buttons_press), 0);

        // 2: clean press and release of bit 0
        #0.5 buttons_raw = '0; switches_raw = '0;
        repeat (10) cyc();
        chk("t2_idle_lvl", 32'(buttons_level), 0);
        #0.5 buttons_raw = 5'b00001;
        repeat (5) cyc();
        chk("t2_lvl_early", 32'(buttons_level), 0);
        cyc();
        chk("t2_press", 32'(buttons_press), 32'h01);
        chk("t2_lvl", 32'(buttons_level), 32'h01);
        cyc();
        chk("t2_press_end", 32'(buttons_press), 0);
        #0.5 buttons_raw = '0;
        repeat (5) cyc();
        chk("t2_rel_early", 32'(buttons_release), 0);
        cyc();
        chk("t2_rel", 32'(buttons_release), 32'h01);

        // 3: bounce on bit 2 is rejected
        pat3 = '{5'h04, 5'h04, 5'h04, 5'h00, 5'h04, 5'h04,
                 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        for (int k = 0; k < 12; k++) begin
            #0.5 buttons_raw = pat3[k];
            cyc();
            chk("t3_press", 32'(buttons_press), 0);
            chk("t3_lvl", 32'(buttons_level), 0);
        end

        // 4: switch word updates
        #0.5 switches_raw = 24'h008000;
        repeat (5) cyc();
        chk("t4_sw_early", 32'(switches_stable), 0);
        cyc();
        chk("t4_sw", 32'(switches_stable), 32'h008000);
        chk("t4_chg", 32'(switches_changed), 1);
        cyc();
        chk("t4_chg_end", 32'(switches_changed), 0);
        #0.5 switches_raw = 24'h808000;
        repeat (5) cyc();
        chk("t4_sw2_early", 32'(switches_stable), 32'h008000);
        cyc();
        chk("t4_sw2", 32'(switches_stable), 32'h808000);
        chk("t4_chg2", 32'(switches_changed), 1);

        // 5: simultaneous presses
        #0.5 buttons_raw = 5'b01010;
        repeat (5) cyc();
        chk("t5_press_early", 32'(buttons_press), 0);
        cyc();
        chk("t5_press", 32'(buttons_press), 32'h0A);
        #0.5 buttons_raw = '0;
        repeat (10) cyc();

        // 6: reset mid-count
        #0.5 buttons_raw = 5'b10000;
        repeat (4) cyc();
        #0.5 reset_n = 1'b0;
        #0.1;
        chk("t6_rst_sw", 32'(switches_stable), 0);
        chk("t6_rst_lvl", 32'(buttons_level), 0);
        cyc();
        chk("t6_rst_press", 32'(buttons_press), 0);
        #0.5 reset_n = 1'b1;
        repeat (5) cyc();
        chk("t6_press_early", 32'(buttons_press), 0);
        cyc();
        chk("t6_press", 32'(buttons_press), 32'h10);
        chk("t6_lvl", 32'(buttons_level), 32'h10);

        // Random bouncing inputs with occasional resets
        bh = 0;
        sh = 0;
        for (int k = 0; k < 3000; k++) begin
            #0.5;
            if (bh == 0) begin
                buttons_raw = buttons_raw ^ BW'($urandom);
                bh = $urandom_range(1, 7);
            end else begin
                bh--;
            end
            if (sh == 0) begin
                if ($urandom_range(0, 1) == 0)
                    switches_raw = SW'($urandom);
                else
                    switches_raw = switches_raw ^ (SW'(1) << $urandom_range(0, SW - 1));
                sh = $urandom_range(1, 8);
            end else begin
                sh--;
            end
            if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            else                             reset_n = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/minisys_input_conditioner.md
Name: minisys_input_conditioner

Overview:
- Front-end stage between the Minisys board pins (24 switches, 5 buttons) and the CPU top's memory-mapped IO input port.
- Synchronises every raw input into the clock domain with a 2-flop synchroniser.
- Debounces each button independently and the switch bank as one word.
- Produces stable levels plus one-cycle press/release/change pulses for the IO read logic and the single-step controller.

Parameters:
- SW_WIDTH, 24, number of switch inputs.
- BTN_WIDTH, 5, number of button inputs.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level is accepted. Must be >= 1; benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- switches_raw  input  SW_WIDTH  board switches, asynchronous.
- buttons_raw  input  BTN_WIDTH  board buttons, asynchronous, 1 = pressed.
- switches_stable  output  SW_WIDTH  debounced switch word.
- switches_changed  output  1  one-cycle pulse when switches_stable updates.
- buttons_level  output  BTN_WIDTH  debounced button levels.
- buttons_press  output  BTN_WIDTH  one-cycle pulse per bit on a debounced 0->1 transition.
- buttons_release  output  BTN_WIDTH  one-cycle pulse per bit on a debounced 1->0 transition.

Behaviour:
- Reset (reset_n low, asynchronous): all synchroniser flops, counters and outputs are 0. This holds regardless of the raw inputs. Leaving reset is synchronous to the next clock edge.
- Synchroniser: sync1 <= raw; sync2 <= sync1. Only sync2 feeds the debounce logic.
- Debounce cell (per button bit; one cell for the whole switch word):
  - Keeps `stable` and a counter `cnt`.
  - On each edge where sync2 != stable: if cnt == DEBOUNCE_CYCLES-1, then stable <= sync2 and cnt <= 0; otherwise cnt <= cnt+1.
  - On each edge where sync2 == stable: cnt <= 0.
  - Any bounce shorter than DEBOUNCE_CYCLES consecutive differing cycles is therefore discarded.
- Switch word: any bit difference counts as "differing". If the word changes to a different non-stable value mid-count, the counter keeps running, and the value accepted is sync2 at the accepting edge. This is an accepted simplification.
- Latency: a raw change settled before edge 1 appears on the stable output after edge DEBOUNCE_CYCLES+2. Breakdown: edge 1 loads sync1, edge 2 loads sync2, edges 3..N+2 count.
- Pulses:
  - buttons_press, buttons_release and switches_changed are registered on the same edge as the stable update, so they are coincident with the first cycle of the new level.
  - Each pulse is exactly 1 cycle wide and is 0 otherwise.
- Simultaneous events: each button cell is independent, so several press bits may pulse in the same cycle.
- Buttons held during reset: after release, the 1 is accepted normally and a press pulse is generated. The single-step logic relies on this.
- Reset mid-count: the counter clears and stable returns to 0. No pulse is emitted on reset entry or exit.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Decomposition:
- Shared package minisys_io_pkg holds:
  - SW_WIDTH/BTN_WIDTH defaults (24/5).
  - Button index constants: BTN_RESET=4, BTN_STEP=0, others reserved.
  - The simulation debounce value DEBOUNCE_SIM=4.
- Sub-module debounce_cell, parameterised by WIDTH and DEBOUNCE_CYCLES. It contains the synchroniser, counter, stable register and rise/fall pulse outputs.
  - Instantiated BTN_WIDTH times with WIDTH=1.
  - Instantiated once with WIDTH=SW_WIDTH.
  - For the switch cell, switches_changed is the OR of the cell's rise and fall vectors.

Test Plan (DEBOUNCE_CYCLES=4, 2 ns clock):
1. Reset: hold reset_n=0 with buttons_raw=5'b11111 and switches_raw=24'hFFFFFF -> all outputs 0. Release reset -> buttons_level=5'b11111 and buttons_press=5'b11111 for exactly 1 cycle, 6 edges after release.
2. Clean press: buttons_raw[0] 0->1 held -> buttons_level[0]=1 after edge 6, buttons_press=5'b00001 for one cycle. Release -> buttons_release=5'b00001 after 6 edges.
3. Bounce rejection: buttons_raw[2] toggled high for 3 cycles, low 1, high 2, then low -> buttons_level stays 0, no press pulse.
4. Switch word: switches_raw changes 24'h0 -> 24'h008000 -> switches_stable=24'h008000 after 6 edges with a one-cycle switches_changed. Then 24'h808000 -> second pulse and new value.
5. Simultaneous: buttons_raw[1] and buttons_raw[3] rise on the same cycle -> buttons_press=5'b01010 in a single cycle.
6. Reset mid-count: raise buttons_raw[4] and assert reset_n=0 after 2 counting edges -> outputs 0 immediately, no pulse. After release, the press is accepted 6 edges later.
